mult2_sweep_checker: RTL and testbench

- Exhaustive operand sequencer and result checker placed around a small combinational multiplier (default 2x2 -> 4-bit product).
- Upstream, it drives every {A,B} operand pair to the multiplier's inputs.
- Downstream, it samples the multiplier's product, compares it with the exact product, and reports mismatch count and first failing vector.
- Used to qualify generated/corrected multiplier netlists in-system and on the bench.

---
 rtl/mult2_sweep_checker.sv | 127 ++++++++++++
 tb/tb_mult2_sweep_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mult2_sweep_checker.sv
// Exhaustive operand sequencer and product checker wrapped around a small
// combinational multiplier; counts mismatches and captures the first failing vector.
module mult2_sweep_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [2*WIDTH-1:0]   prod_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic                 first_fail_valid,
    output logic [2*WIDTH-1:0]   first_fail_vec,
    output logic [2*WIDTH-1:0]   first_fail_prod
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   idx_reg, idx_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [PW:0]     err_reg, err_next;
    logic            ffv_reg, ffv_next;
    logic [PW-1:0]   ffvec_reg, ffvec_next;
    logic [PW-1:0]   ffprod_reg, ffprod_next;

    logic [PW-1:0]   exp_prod;
    logic            mismatch;

    // Operands are zero-extended so the reference product is never truncated.
    assign exp_prod = PW'(op_a) * PW'(op_b);
    assign mismatch = (prod_in != exp_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            err_reg    <= '0;
            ffv_reg    <= 1'b0;
            ffvec_reg  <= '0;
            ffprod_reg <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            err_reg    <= err_next;
            ffv_reg    <= ffv_next;
            ffvec_reg  <= ffvec_next;
            ffprod_reg <= ffprod_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        err_next    = err_reg;
        ffv_next    = ffv_reg;
        ffvec_next  = ffvec_reg;
        ffprod_next = ffprod_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next  = DRIVE;
                    idx_next    = '0;
                    cnt_next    = '0;
                    err_next    = '0;
                    ffv_next    = 1'b0;
                    ffvec_next  = '0;
                    ffprod_next = '0;
                end
            end
            DRIVE: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_next = err_reg + (PW + 1)'(1);
                    if (!ffv_reg) begin
                        ffv_next    = 1'b1;
                        ffvec_next  = idx_reg;
                        ffprod_next = prod_in;
                    end
                end
                // idx stays at all-ones in DONE so the last vector remains on the operands.
                if (idx_reg == {PW{1'b1}}) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + PW'(1);
                    cnt_next   = '0;
                    state_next = DRIVE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign {op_a, op_b}     = (state_reg == IDLE) ? '0 : idx_reg;
    assign busy             = (state_reg == DRIVE) || (state_reg == SAMPLE);
    assign done             = (state_reg == DONE);
    assign pass             = (state_reg == DONE) && (err_reg == '0);
    assign err_count        = err_reg;
    assign first_fail_valid = ffv_reg;
    assign first_fail_vec   = ffvec_reg;
    assign first_fail_prod  = ffprod_reg;

endmodule

// File: tb/tb_mult2_sweep_checker.sv
// Directed bench: exact, corrupted, stuck-at-zero and glitchy multiplier models
// in front of two checker instances (SETTLE=1 and SETTLE=3).
module tb_mult2_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    int         mode = 0;   // 0 exact, 1 corrupt {A,B}=0110, 2 stuck at zero

    logic [1:0] a1, b1, a3, b3;
    logic [3:0] prod1, prod3, exact1, exact3;
    logic       busy1, done1, pass1, ffv1;
    logic       busy3, done3, pass3, ffv3;
    logic [4:0] err1, err3;
    logic [3:0] ffvec1, ffprod1, ffvec3, ffprod3;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mult2_sweep_checker #(.WIDTH(2), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .op_a(a1), .op_b(b1), .prod_in(prod1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_valid(ffv1), .first_fail_vec(ffvec1), .first_fail_prod(ffprod1)
    );

    mult2_sweep_checker #(.WIDTH(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .op_a(a3), .op_b(b3), .prod_in(prod3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail_valid(ffv3), .first_fail_vec(ffvec3), .first_fail_prod(ffprod3)
    );

    // Multiplier models.
    assign exact1 = {2'b00, a1} * {2'b00, b1};
    assign exact3 = {2'b00, a3} * {2'b00, b3};

    always_comb begin
        prod1 = exact1;
        if (mode == 2) prod1 = 4'd0;
        else if (mode == 1 && {a1, b1} == 4'b0110) prod1 = 4'd0;
    end

    // Glitchy model: wrong for the first two cycles a vector is presented.
    logic [3:0] last3 = 4'd0;
    logic       last_busy3 = 1'b0;
    logic [1:0] age3 = 2'd0;
    logic       new3, glitch3;
    assign new3    = ({a3, b3} != last3) || !last_busy3;
    assign glitch3 = new3 || (age3 == 2'd0);
    assign prod3   = glitch3 ? ~exact3 : exact3;

    always @(posedge clk) begin
        last3      <= {a3, b3};
        last_busy3 <= busy3;
        age3       <= new3 ? 2'd0 : ((age3 == 2'd3) ? 2'd3 : age3 + 2'd1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    // Counts edges after the start-sampling edge until done is seen (bounded).
    task automatic wait_done(input bit which, output int n);
        n = 0;
        while (((which == 1'b0) ? !done1 : !done3) && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ops"},  {28'd0, a1, b1}, 32'd0);
        chk({tag, " flags"}, {28'd0, busy1, done1, pass1, ffv1}, 32'd0);
        chk({tag, " err"},  {27'd0, err1}, 32'd0);
        chk({tag, " ffvp"}, {24'd0, ffvec1, ffprod1}, 32'd0);
    endtask

    int n;

    initial begin
        // Reset state
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        chk_all_zero("idle");

        // Exact model: walk every vector, 2 cycles each
        mode = 0;
        pulse1();
        for (int v = 0; v < 16; v++) begin
            chk($sformatf("drive vec%0d", v), {28'd0, a1, b1}, v);
            chk($sformatf("drive busy%0d", v), {31'd0, busy1}, 32'd1);
            tick();
            chk($sformatf("sample vec%0d", v), {28'd0, a1, b1}, v);
            if (v == 15) chk("done before last edge", {31'd0, done1}, 32'd0);
            tick();
        end
        chk("exact done", {31'd0, done1}, 32'd1);
        chk("exact busy", {31'd0, busy1}, 32'd0);
        chk("exact pass", {31'd0, pass1}, 32'd1);
        chk("exact err", {27'd0, err1}, 32'd0);
        chk("exact ffv", {31'd0, ffv1}, 32'd0);
        chk("exact hold vec", {28'd0, a1, b1}, 32'hF);
        tick();
        chk("done level", {31'd0, done1}, 32'd1);

        // Single corrupted vector 0110
        mode = 1;
        pulse1();
        wait_done(1'b0, n);
        chk("corrupt latency", n, 32'd32);
        chk("corrupt err", {27'd0, err1}, 32'd1);
        chk("corrupt ffv", {31'd0, ffv1}, 32'd1);
        chk("corrupt ffvec", {28'd0, ffvec1}, 32'h6);
        chk("corrupt ffprod", {28'd0, ffprod1}, 32'h0);
        chk("corrupt pass", {31'd0, pass1}, 32'd0);

        // Stuck-at-zero product
        mode = 2;
        pulse1();
        wait_done(1'b0, n);
        chk("stuck err", {27'd0, err1}, 32'd9);
        chk("stuck ffvec", {28'd0, ffvec1}, 32'h5);
        chk("stuck ffprod", {28'd0, ffprod1}, 32'h0);
        chk("stuck pass", {31'd0, pass1}, 32'd0);

        // Restart from DONE with exact model: stats cleared on the start edge
        mode = 0;
        pulse1();
        chk("restart err clr", {27'd0, err1}, 32'd0);
        chk("restart ffv clr", {31'd0, ffv1}, 32'd0);
        chk("restart ffvec clr", {28'd0, ffvec1}, 32'd0);
        chk("restart done low", {31'd0, done1}, 32'd0);
        wait_done(1'b0, n);
        chk("restart pass", {31'd0, pass1}, 32'd1);

        // Asynchronous reset mid-sweep
        mode = 2;
        pulse1();
        for (int i = 0; i < 14; i++) tick();
        chk("mid err", {27'd0, err1}, 32'd2);
        chk("mid ffvec", {28'd0, ffvec1}, 32'h5);
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("async rst");
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        chk_all_zero("post rst");
        mode = 0;
        pulse1();
        wait_done(1'b0, n);
        chk("post rst latency", n, 32'd32);
        chk("post rst pass", {31'd0, pass1}, 32'd1);
        chk("post rst err", {27'd0, err1}, 32'd0);

        // start held high through the sweep
        start1 = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) tick();
        chk("held no restart vec", {28'd0, a1, b1}, 32'h8);
        chk("held busy", {31'd0, busy1}, 32'd1);
        wait_done(1'b0, n);
        chk("held latency", n, 32'd16);
        tick();
        chk("held restart done", {31'd0, done1}, 32'd0);
        chk("held restart busy", {31'd0, busy1}, 32'd1);
        chk("held restart vec", {28'd0, a1, b1}, 32'h0);
        start1 = 1'b0;
        wait_done(1'b0, n);

        // SETTLE=3 with a glitchy multiplier
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        wait_done(1'b1, n);
        chk("settle3 latency", n, 32'd64);
        chk("settle3 pass", {31'd0, pass3}, 32'd1);
        chk("settle3 err", {27'd0, err3}, 32'd0);
        chk("settle3 ffv", {31'd0, ffv3}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
